// File: rtl/tick_sched_pkg.sv
// Shared types and default constants for the run/pause/single-step tick scheduler.
package tick_sched_pkg;

   // Controller state; 2'b11 is never entered and is treated as IDLE.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      STEP = 2'b10
   } state_t;

   // Default divider width, tick periods (in clk cycles) and tick counter width.
   localparam int DIV_W_DEF = 28;
   localparam int DIV0_DEF  = 62_500_000;
   localparam int DIV1_DEF  = 31_250_000;
   localparam int DIV2_DEF  = 12_500_000;
   localparam int DIV3_DEF  = 6_250_000;
   localparam int CNT_W_DEF = 16;

   // A period must be at least 2 (so RUN ticks never touch) and fit the divider.
   function automatic bit div_ok(input longint d, input int w);
      return (d >= 64'sd2) && (d < (64'sd1 <<< w));
   endfunction

endpackage

// File: rtl/tick_sched_if.sv
// Control/status bundle between the board-side controls and the tick scheduler.
interface tick_sched_if #(
   parameter int CNT_W = tick_sched_pkg::CNT_W_DEF
) ();
   logic             run_req;
   logic             step_req;
   logic [1:0]       speed;
   logic             tick;
   logic             busy;
   logic [1:0]       state_o;
   logic [CNT_W-1:0] tick_count;

   // Driver of the control levels (switches/buttons side).
   modport master (
      output run_req, step_req, speed,
      input  tick, busy, state_o, tick_count
   );

   // The scheduler itself.
   modport slave (
      input  run_req, step_req, speed,
      output tick, busy, state_o, tick_count
   );
endinterface

// File: rtl/tick_div.sv
// Loadable period divider: counts 0..term-1 while enabled and flags the last count.
module tick_div
   import tick_sched_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [DIV_W-1:0] term,
   output logic             wrap,
   output logic [DIV_W-1:0] count
);
   logic [DIV_W-1:0] count_q;
   logic [DIV_W-1:0] count_d;

   // Last count of the current period, only meaningful while counting.
   assign wrap  = en && (count_q == (term - DIV_W'(1)));
   assign count = count_q;

   // Next count: clear wins, wrap restarts the period, otherwise advance.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = wrap ? '0 : count_q + DIV_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end
endmodule

// File: rtl/tick_sched.sv
// Run/pause/single-step controller producing the one-cycle clock-enable tick.
module tick_sched
   import tick_sched_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF,
   parameter int DIV0  = DIV0_DEF,
   parameter int DIV1  = DIV1_DEF,
   parameter int DIV2  = DIV2_DEF,
   parameter int DIV3  = DIV3_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input logic          clk,
   input logic          rst,
   tick_sched_if.slave  bus
);
   // Reject unusable periods at elaboration time.
   if (!div_ok(DIV0, DIV_W) || !div_ok(DIV1, DIV_W) ||
       !div_ok(DIV2, DIV_W) || !div_ok(DIV3, DIV_W)) begin : g_bad_div
      $error("tick_sched: every DIVn must be >= 2 and < 2**DIV_W");
   end

   state_t           state_q, state_d;
   logic [DIV_W-1:0] term_q, term_d;
   logic [DIV_W-1:0] term_sel;
   logic             tick_q, tick_d;
   logic             busy_q;
   logic [CNT_W-1:0] tcnt_q;
   logic             div_clr, div_en, div_wrap;
   logic [DIV_W-1:0] div_count;

   // Period for the currently selected speed.
   always_comb begin
      term_sel = DIV_W'(DIV0);
      case (bus.speed)
         2'd0: term_sel = DIV_W'(DIV0);
         2'd1: term_sel = DIV_W'(DIV1);
         2'd2: term_sel = DIV_W'(DIV2);
         2'd3: term_sel = DIV_W'(DIV3);
         default: term_sel = DIV_W'(DIV0);
      endcase
   end

   // The divider only runs while in RUN with run still requested; anything else parks it at 0.
   assign div_en  = (state_q == RUN) && bus.run_req;
   assign div_clr = !div_en;

   tick_div #(.DIV_W(DIV_W)) u_div (
      .clk   (clk),
      .rst   (rst),
      .clr   (div_clr),
      .en    (div_en),
      .term  (term_q),
      .wrap  (div_wrap),
      .count (div_count)
   );

   // Next state, period latch and tick request.
   always_comb begin
      state_d = state_q;
      term_d  = term_q;
      tick_d  = 1'b0;
      case (state_q)
         RUN: begin
            // Leaving RUN beats a coincident wrap, so no tick on the way out.
            if (!bus.run_req) begin
               state_d = IDLE;
            end else if (div_wrap) begin
               tick_d = 1'b1;
               term_d = term_sel;   // new speed takes effect only at a period boundary
            end
         end
         STEP: begin
            // One tick per press: wait here until the button is released.
            if (!bus.step_req) begin
               state_d = IDLE;
            end
         end
         default: begin
            // IDLE (and the unused encoding): track the speed, run beats step.
            term_d = term_sel;
            if (bus.run_req) begin
               state_d = RUN;
            end else if (bus.step_req) begin
               state_d = STEP;
               tick_d  = 1'b1;
            end
         end
      endcase
   end

   // State, period, tick, busy and tick counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         term_q  <= DIV_W'(DIV0);
         tick_q  <= 1'b0;
         busy_q  <= 1'b0;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         term_q  <= term_d;
         tick_q  <= tick_d;
         busy_q  <= (state_d != IDLE);
         if (tick_d) begin
            tcnt_q <= tcnt_q + CNT_W'(1);
         end
      end
   end

   // The running divider never reaches its period.
   a_count_in_range: assert property (@(posedge clk) disable iff (rst)
      (state_q == RUN) |-> (div_count < term_q));

   assign bus.tick       = tick_q;
   assign bus.busy       = busy_q;
   assign bus.state_o    = state_q;
   assign bus.tick_count = tcnt_q;
endmodule

// File: tb/tb_tick_sched.sv
// Directed bench for tick_sched with a per-cycle reference model and literal spot checks.
module tb_tick_sched;
   import tick_sched_pkg::*;

   localparam int CNT_W = 8;
   int dv [4] = '{8, 4, 3, 2};

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   tick_sched_if #(.CNT_W(CNT_W)) bus ();

   tick_sched #(
      .DIV_W(8), .DIV0(8), .DIV1(4), .DIV2(3), .DIV3(2), .CNT_W(CNT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int nvec  = 0;
   int nfail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reference model: tracks mode and the absolute edge number of the next RUN tick.
   int     m_mode  = 0;      // 0 idle, 1 run, 2 step
   bit     m_tick  = 0;
   int     m_cnt   = 0;
   longint m_next  = 0;
   longint m_edge  = 0;
   bit     m_valid = 0;

   always @(posedge clk) begin : model
      int     mode;
      bit     tk;
      int     cnt;
      longint nxt;
      mode = m_mode;
      tk   = 0;
      cnt  = m_cnt;
      nxt  = m_next;
      if (rst) begin
         mode = 0;
         cnt  = 0;
         m_valid <= 1'b1;
      end else begin
         case (mode)
            1: begin
               if (!bus.run_req) mode = 0;
               else if (m_edge == nxt) begin
                  tk  = 1;
                  nxt = m_edge + dv[bus.speed];
               end
            end
            2: if (!bus.step_req) mode = 0;
            default: begin
               if (bus.run_req) begin
                  mode = 1;
                  nxt  = m_edge + dv[bus.speed];
               end else if (bus.step_req) begin
                  mode = 2;
                  tk   = 1;
               end
            end
         endcase
         if (tk) cnt = (cnt + 1) % (1 << CNT_W);
      end
      m_mode <= mode;
      m_tick <= tk;
      m_cnt  <= cnt;
      m_next <= nxt;
      m_edge <= m_edge + 1;
   end

   // Compare DUT against the model on every falling edge once reset has been seen.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("model_tick",  32'(bus.tick),       32'(m_tick));
         chk("model_state", 32'(bus.state_o),    32'(m_mode));
         chk("model_busy",  32'(bus.busy),       32'(m_mode != 0));
         chk("model_count", 32'(bus.tick_count), 32'(m_cnt));
      end
   end

   initial begin : stim
      int  prev;
      bit  found;
      rst          = 1'b1;
      bus.run_req  = 1'b0;
      bus.step_req = 1'b0;
      bus.speed    = 2'd0;

      // 1: reset, then idle
      cyc(); cyc();
      rst = 1'b0;
      repeat (5) cyc();
      chk("t1_tick", 32'(bus.tick), 0);
      chk("t1_busy", 32'(bus.busy), 0);
      chk("t1_state", 32'(bus.state_o), 0);
      chk("t1_count", 32'(bus.tick_count), 0);
      $display("t1 reset/idle done");

      // 2: speed 1 free-run, ticks after E4, E8, E12
      bus.speed = 2'd1; bus.run_req = 1'b1;
      cyc();
      for (int k = 1; k <= 12; k++) begin
         cyc();
         chk("t2_tick", 32'(bus.tick), 32'(k % 4 == 0));
      end
      chk("t2_count", 32'(bus.tick_count), 3);
      chk("t2_state", 32'(bus.state_o), 1);
      chk("t2_busy", 32'(bus.busy), 1);
      bus.run_req = 1'b0;
      cyc();
      chk("t2_stop", 32'(bus.state_o), 0);
      $display("t2 run speed1 done, tick_count=%0d", bus.tick_count);

      // 3: speed 0, switch to speed 3 mid-period
      bus.speed = 2'd0; bus.run_req = 1'b1;
      cyc();
      for (int k = 1; k <= 20; k++) begin
         cyc();
         if (k == 11) bus.speed = 2'd3;
         chk("t3_tick", 32'(bus.tick), 32'(k == 8 || k == 16 || k == 18 || k == 20));
      end
      bus.run_req = 1'b0;
      cyc();
      chk("t3_state", 32'(bus.state_o), 0);
      chk("t3_count", 32'(bus.tick_count), 7);
      $display("t3 speed change done, tick_count=%0d", bus.tick_count);

      // 4: drop run at the would-be wrap, then restart
      bus.speed = 2'd2; bus.run_req = 1'b1;
      cyc(); cyc(); cyc();
      bus.run_req = 1'b0;
      cyc();
      chk("t4_notick", 32'(bus.tick), 0);
      chk("t4_idle", 32'(bus.state_o), 0);
      bus.run_req = 1'b1;
      cyc();
      chk("t4_rerun", 32'(bus.state_o), 1);
      for (int k = 1; k <= 3; k++) begin
         cyc();
         chk("t4_tick", 32'(bus.tick), 32'(k == 3));
      end
      chk("t4_count", 32'(bus.tick_count), 8);
      bus.run_req = 1'b0;
      cyc();
      $display("t4 drop/restart done, tick_count=%0d", bus.tick_count);

      // 5: held step gives one tick per press
      bus.step_req = 1'b1;
      cyc();
      chk("t5_tick1", 32'(bus.tick), 1);
      chk("t5_state", 32'(bus.state_o), 2);
      for (int k = 1; k <= 9; k++) begin
         cyc();
         chk("t5_hold", 32'(bus.tick), 0);
      end
      bus.step_req = 1'b0;
      cyc();
      chk("t5_rel", 32'(bus.state_o), 0);
      bus.step_req = 1'b1;
      cyc();
      chk("t5_tick2", 32'(bus.tick), 1);
      cyc();
      chk("t5_once", 32'(bus.tick), 0);
      bus.step_req = 1'b0;
      cyc();
      chk("t5_count", 32'(bus.tick_count), 10);
      bus.speed = 2'd3; bus.run_req = 1'b1; bus.step_req = 1'b1;
      cyc();
      chk("t5_both_state", 32'(bus.state_o), 1);
      chk("t5_both_tick", 32'(bus.tick), 0);
      bus.step_req = 1'b0;
      $display("t5 step done, tick_count=%0d", bus.tick_count);

      // 6: tick_count wrap at speed 3, then reset mid-RUN and mid-STEP
      found = 1'b0;
      prev  = int'(bus.tick_count);
      for (int k = 0; k < 1200 && !found; k++) begin
         cyc();
         if (bus.tick && prev == (1 << CNT_W) - 1) begin
            chk("t6_wrap", 32'(bus.tick_count), 0);
            found = 1'b1;
         end
         prev = int'(bus.tick_count);
      end
      chk("t6_wrap_seen", 32'(found), 1);
      rst = 1'b1;
      cyc();
      chk("t6_rst_tick", 32'(bus.tick), 0);
      chk("t6_rst_state", 32'(bus.state_o), 0);
      chk("t6_rst_count", 32'(bus.tick_count), 0);
      chk("t6_rst_busy", 32'(bus.busy), 0);
      rst = 1'b0; bus.run_req = 1'b0; bus.step_req = 1'b1;
      cyc();
      chk("t6_step", 32'(bus.state_o), 2);
      rst = 1'b1;
      cyc();
      chk("t6_rst_step", 32'(bus.state_o), 0);
      rst = 1'b0; bus.step_req = 1'b0;
      repeat (3) cyc();
      $display("t6 wrap/reset done");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
